// File: rtl/check_uart_reporter_if.sv
// Check-request / report signal bundle for check_uart_reporter.
// master: self-test logic (or bench) side; slave: the reporter itself.
interface check_uart_reporter_if #(
  parameter int CNT_W = 16
);
  logic             chk_valid;
  logic             chk_ready;
  logic [31:0]      chk_expected;
  logic [31:0]      chk_actual;
  logic             sum_req;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] fail_count;
  logic             busy;
  logic             uart_tx;

  modport master (
    output chk_valid, chk_expected, chk_actual, sum_req,
    input  chk_ready, pass_count, fail_count, busy, uart_tx
  );

  modport slave (
    input  chk_valid, chk_expected, chk_actual, sum_req,
    output chk_ready, pass_count, fail_count, busy, uart_tx
  );
endinterface

// File: rtl/check_uart_reporter.sv
// Compares expected/actual word pairs, keeps saturating pass/fail counters and
// reports each verdict ('P'/'F') plus on-demand summary frames over an 8N1 UART.
//
// seq state | meaning
// SEQ_IDLE  | ready for a check, or about to start a pending summary
// SEQ_BYTE  | verdict byte in flight
// SEQ_SUM   | summary frame in flight, sum_k_q selects the byte (0..4)
//
// tx state  | meaning
// TX_IDLE   | line idle high
// TX_START  | start bit (low) for WAIT cycles
// TX_DATA   | data bits LSB first, bit_q counts down 7..0
// TX_STOP   | stop bit (high); terminal count ends the byte
module check_uart_reporter #(
  parameter int WAIT  = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  check_uart_reporter_if.slave bus
);
  localparam int BW = $clog2(WAIT);
  localparam logic [BW-1:0] BAUD_TC = BW'(WAIT - 1);

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_BYTE, SEQ_SUM} seq_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_e;

  seq_e             seq_q, seq_d;
  logic [2:0]       sum_k_q, sum_k_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] snap_pass_q, snap_pass_d;
  logic [CNT_W-1:0] snap_fail_q, snap_fail_d;
  logic             vrd_vld_q, vrd_vld_d;
  logic             vrd_fail_q, vrd_fail_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  tx_e              tx_q, tx_d;
  logic [BW-1:0]    baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;

  logic             chk_fire;
  logic             pend_now;
  logic             tx_done;
  logic             start_sum;
  logic             tx_load;
  logic [7:0]       tx_byte;

  function automatic logic [7:0] sum_byte(input logic [2:0] k,
                                          input logic [CNT_W-1:0] sp,
                                          input logic [CNT_W-1:0] sf);
    case (k)
      3'd1:    return sp[15:8];
      3'd2:    return sp[7:0];
      3'd3:    return sf[15:8];
      3'd4:    return sf[7:0];
      default: return 8'h53;
    endcase
  endfunction

  assign bus.chk_ready  = ~rst && (seq_q == SEQ_IDLE) && ~pend_q;
  assign bus.busy       = (seq_q != SEQ_IDLE) || pend_q;
  assign bus.pass_count = pass_cnt_q;
  assign bus.fail_count = fail_cnt_q;
  assign bus.uart_tx    = (tx_q == TX_START) ? 1'b0 :
                          (tx_q == TX_DATA)  ? shift_q[0] : 1'b1;

  assign chk_fire = bus.chk_valid && bus.chk_ready;
  assign pend_now = pend_q || bus.sum_req;
  assign tx_done  = (tx_q == TX_STOP) && (baud_q == '0);

  always_comb begin
    seq_d       = seq_q;
    sum_k_d     = sum_k_q;
    pend_d      = pend_now;
    snap_pass_d = snap_pass_q;
    snap_fail_d = snap_fail_q;
    vrd_vld_d   = 1'b0;
    vrd_fail_d  = vrd_fail_q;
    start_sum   = 1'b0;
    tx_load     = 1'b0;
    tx_byte     = 8'h00;

    case (seq_q)
      SEQ_IDLE: begin
        if (chk_fire) begin
          vrd_vld_d  = 1'b1;
          vrd_fail_d = (bus.chk_expected != bus.chk_actual);
          tx_load    = 1'b1;
          tx_byte    = vrd_fail_d ? 8'h46 : 8'h50;
          seq_d      = SEQ_BYTE;
        end else if (pend_q) begin
          start_sum = 1'b1;
        end
      end
      SEQ_BYTE: begin
        if (tx_done) begin
          if (pend_now) start_sum = 1'b1;
          else          seq_d     = SEQ_IDLE;
        end
      end
      SEQ_SUM: begin
        if (tx_done) begin
          if (sum_k_q == 3'd4) begin
            seq_d = SEQ_IDLE;
          end else begin
            sum_k_d = sum_k_q + 3'd1;
            tx_load = 1'b1;
            tx_byte = sum_byte(sum_k_d, snap_pass_q, snap_fail_q);
          end
        end
      end
      default: seq_d = SEQ_IDLE;
    endcase

    // A request landing on the frame-start edge merges into this frame.
    if (start_sum) begin
      seq_d       = SEQ_SUM;
      sum_k_d     = 3'd0;
      pend_d      = 1'b0;
      snap_pass_d = pass_cnt_q;
      snap_fail_d = fail_cnt_q;
      tx_load     = 1'b1;
      tx_byte     = 8'h53;
    end
  end

  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (vrd_vld_q) begin
      if (!vrd_fail_q && (pass_cnt_q != '1)) pass_cnt_d = pass_cnt_q + 1'b1;
      if ( vrd_fail_q && (fail_cnt_q != '1)) fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  always_comb begin
    tx_d    = tx_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    case (tx_q)
      TX_IDLE: begin
        if (tx_load) begin
          tx_d    = TX_START;
          baud_d  = BAUD_TC;
          shift_d = tx_byte;
        end
      end
      TX_START: begin
        if (baud_q == '0) begin
          tx_d   = TX_DATA;
          baud_d = BAUD_TC;
          bit_d  = 3'd7;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      TX_DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_TC;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd0) tx_d  = TX_STOP;
          else               bit_d = bit_q - 3'd1;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      TX_STOP: begin
        if (baud_q == '0) begin
          // Chain straight into the next byte so summary bytes have no gap.
          if (tx_load) begin
            tx_d    = TX_START;
            baud_d  = BAUD_TC;
            shift_d = tx_byte;
          end else begin
            tx_d = TX_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: tx_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q       <= SEQ_IDLE;
      sum_k_q     <= 3'd0;
      pend_q      <= 1'b0;
      snap_pass_q <= '0;
      snap_fail_q <= '0;
      vrd_vld_q   <= 1'b0;
      vrd_fail_q  <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      tx_q        <= TX_IDLE;
      baud_q      <= '0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
    end else begin
      seq_q       <= seq_d;
      sum_k_q     <= sum_k_d;
      pend_q      <= pend_d;
      snap_pass_q <= snap_pass_d;
      snap_fail_q <= snap_fail_d;
      vrd_vld_q   <= vrd_vld_d;
      vrd_fail_q  <= vrd_fail_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      tx_q        <= tx_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
    end
  end
endmodule
